// File: rtl/lane_draw_pkg.sv
// Shared definitions for the lane draw scheduler: FSM encoding, screen limits and coord widths.
package lane_draw_pkg;

  localparam int unsigned XW = 9;
  localparam int unsigned YW = 8;
  localparam int unsigned CW = 3;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam logic [CW-1:0] COLOUR_BG = 3'b000;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StErase,
    StDraw,
    StAck,
    StDone
  } state_e;

endpackage

// File: rtl/block_scanner.sv
// Row-major NOTE_W x NOTE_H offset generator; dx/dy/last describe the pixel to be issued next.
module block_scanner
  import lane_draw_pkg::*;
#(
  parameter int unsigned NOTE_W = 8,
  parameter int unsigned NOTE_H = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          advance,
  output logic [XW-1:0] dx,
  output logic [YW-1:0] dy,
  output logic          last
);

  localparam int unsigned NPix = NOTE_W * NOTE_H;
  localparam int unsigned CntW = (NPix > 1) ? $clog2(NPix) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(NPix - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     cnt_ext;

  assign last    = (cnt_q == CntMax);
  assign cnt_ext = 32'(cnt_q);
  assign dx      = XW'(cnt_ext % NOTE_W);
  assign dy      = YW'(cnt_ext / NOTE_W);

  // Wraps back to zero after the last pixel so the next block starts clean.
  always_comb begin
    cnt_d = cnt_q;
    if (advance) begin
      cnt_d = last ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lane_draw_scheduler.sv
// Round-robin owner of the VGA pixel port: per requesting lane, erase the old block then draw the new.
module lane_draw_scheduler
  import lane_draw_pkg::*;
#(
  parameter int unsigned N_LANES  = 4,
  parameter int unsigned NOTE_W   = 8,
  parameter int unsigned NOTE_H   = 4,
  parameter int unsigned SCREEN_W = lane_draw_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = lane_draw_pkg::SCREEN_H
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic [N_LANES-1:0]      req,
  input  logic [XW*N_LANES-1:0]   erase_x,
  input  logic [YW*N_LANES-1:0]   erase_y,
  input  logic [XW*N_LANES-1:0]   draw_x,
  input  logic [YW*N_LANES-1:0]   draw_y,
  input  logic [CW*N_LANES-1:0]   lane_colour,
  output logic [N_LANES-1:0]      grant,
  output logic [N_LANES-1:0]      ack,
  output logic [XW-1:0]           x_out,
  output logic [YW-1:0]           y_out,
  output logic [CW-1:0]           c_out,
  output logic                    plot,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun
);

  localparam int unsigned PtrW = $clog2(N_LANES);

  state_e               state_q, state_d;
  logic [N_LANES-1:0]   pending_q, pending_d;
  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d, lane_q, lane_d;
  logic [XW-1:0]        ex_q, ex_d, wx_q, wx_d;
  logic [YW-1:0]        ey_q, ey_d, wy_q, wy_d;
  logic [CW-1:0]        colour_q, colour_d;
  logic                 pix_last_q, pix_last_d;
  logic [N_LANES-1:0]   grant_q, grant_d, ack_q, ack_d;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic [CW-1:0]        c_q, c_d;
  logic                 plot_q, plot_d, busy_q, busy_d;
  logic                 frame_done_q, frame_done_d, overrun_q, overrun_d;

  logic                 pick_found;
  logic [PtrW-1:0]      pick_idx, cand;
  logic [XW-1:0]        sel_ex, sel_wx, emit_bx, scan_dx;
  logic [YW-1:0]        sel_ey, sel_wy, emit_by, scan_dy;
  logic [CW-1:0]        sel_col, emit_c;
  logic                 emit_en, scan_last;

  block_scanner #(
    .NOTE_W (NOTE_W),
    .NOTE_H (NOTE_H)
  ) u_scanner (
    .clk     (clk),
    .reset   (reset),
    .advance (emit_en),
    .dx      (scan_dx),
    .dy      (scan_dy),
    .last    (scan_last)
  );

  // First pending lane at or after rr_ptr, wrapping; lowest rotation offset wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = N_LANES - 1; k >= 0; k--) begin
      cand = PtrW'((32'(rr_ptr_q) + 32'(k)) % N_LANES);
      if (pending_q[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign sel_ex  = erase_x[32'(pick_idx) * XW +: XW];
  assign sel_ey  = erase_y[32'(pick_idx) * YW +: YW];
  assign sel_wx  = draw_x[32'(pick_idx) * XW +: XW];
  assign sel_wy  = draw_y[32'(pick_idx) * YW +: YW];
  assign sel_col = lane_colour[32'(pick_idx) * CW +: CW];

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    rr_ptr_d     = rr_ptr_q;
    lane_d       = lane_q;
    ex_d         = ex_q;
    ey_d         = ey_q;
    wx_d         = wx_q;
    wy_d         = wy_q;
    colour_d     = colour_q;
    grant_d      = grant_q;
    ack_d        = '0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q | (frame_tick & (state_q != StIdle));
    emit_en      = 1'b0;
    emit_bx      = wx_q;
    emit_by      = wy_q;
    emit_c       = colour_q;

    unique case (state_q)
      StIdle: begin
        if (frame_tick) begin
          pending_d = req;
          busy_d    = 1'b1;
          state_d   = StSelect;
        end
      end
      StSelect: begin
        if (!pick_found) begin
          frame_done_d = 1'b1;
          state_d      = StDone;
        end else begin
          lane_d   = pick_idx;
          grant_d  = N_LANES'(1) << pick_idx;
          ex_d     = sel_ex;
          ey_d     = sel_ey;
          wx_d     = sel_wx;
          wy_d     = sel_wy;
          colour_d = sel_col;
          emit_en  = 1'b1;
          // An unmoved block is simply redrawn; erasing it first would only flicker.
          if (sel_ex == sel_wx && sel_ey == sel_wy) begin
            emit_bx = sel_wx;
            emit_by = sel_wy;
            emit_c  = sel_col;
            state_d = StDraw;
          end else begin
            emit_bx = sel_ex;
            emit_by = sel_ey;
            emit_c  = COLOUR_BG;
            state_d = StErase;
          end
        end
      end
      StErase: begin
        emit_en = 1'b1;
        if (pix_last_q) begin
          state_d = StDraw;
        end else begin
          emit_bx = ex_q;
          emit_by = ey_q;
          emit_c  = COLOUR_BG;
        end
      end
      StDraw: begin
        if (pix_last_q) begin
          ack_d   = grant_q;
          state_d = StAck;
        end else begin
          emit_en = 1'b1;
        end
      end
      StAck: begin
        pending_d[lane_q] = 1'b0;
        rr_ptr_d = (lane_q == PtrW'(N_LANES - 1)) ? '0 : lane_q + PtrW'(1);
        grant_d  = '0;
        state_d  = StSelect;
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    pix_last_d = emit_en & scan_last;
    x_d        = emit_en ? emit_bx + scan_dx : '0;
    y_d        = emit_en ? emit_by + scan_dy : '0;
    c_d        = emit_en ? emit_c : '0;
    plot_d     = emit_en && (32'(x_d) < SCREEN_W) && (32'(y_d) < SCREEN_H);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      lane_q       <= '0;
      ex_q         <= '0;
      ey_q         <= '0;
      wx_q         <= '0;
      wy_q         <= '0;
      colour_q     <= '0;
      pix_last_q   <= 1'b0;
      grant_q      <= '0;
      ack_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      c_q          <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      lane_q       <= lane_d;
      ex_q         <= ex_d;
      ey_q         <= ey_d;
      wx_q         <= wx_d;
      wy_q         <= wy_d;
      colour_q     <= colour_d;
      pix_last_q   <= pix_last_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      x_q          <= x_d;
      y_q          <= y_d;
      c_q          <= c_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign grant      = grant_q;
  assign ack        = ack_q;
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign c_out      = c_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule
